// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/ANDN) between
// an ALU issue port and a CSR set/clear port, with a single registered response slot.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [1:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [1:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o
);

  logic             r_last_grant;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_slot_free;
  logic             w_grant_id;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  assign w_slot_free = !r_rsp_valid || rsp_ready_i;

  // Contested cycles go to the requester not served last; otherwise the lone valid one.
  always_comb begin
    w_grant_id = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      w_grant_id = ~r_last_grant;
    end
  end

  // Readies are gated by reset so nothing looks accepted while the block is held.
  assign req0_ready_o = rst_ni && w_slot_free && req0_valid_i && !w_grant_id;
  assign req1_ready_o = rst_ni && w_slot_free && req1_valid_i &&  w_grant_id;
  assign w_accept     = req0_ready_o || req1_ready_o;

  assign w_op = w_grant_id ? req1_op_i : req0_op_i;
  assign w_a  = w_grant_id ? req1_a_i  : req0_a_i;
  assign w_b  = w_grant_id ? req1_b_i  : req0_b_i;

  always_comb begin
    w_result = '0;
    unique case (w_op)
      2'b00: w_result = w_a & w_b;
      2'b01: w_result = w_a | w_b;
      2'b10: w_result = w_a ^ w_b;
      2'b11: w_result = w_a & ~w_b;
    endcase
  end

  // An accept overrides a concurrent drain, so back-to-back results have no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant_id;
      r_rsp_data   <= w_result;
      r_last_grant <= w_grant_id;
    end else if (r_rsp_valid && rsp_ready_i) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomized checks of logic_unit_arbiter against a cycle-level
// transaction model of the arbitration and response-slot rules.
module tb_logic_unit_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req0_valid_i = 1'b0;
  logic        req0_ready_o;
  logic [1:0]  req0_op_i = 2'b00;
  logic [31:0] req0_a_i = '0;
  logic [31:0] req0_b_i = '0;
  logic        req1_valid_i = 1'b0;
  logic        req1_ready_o;
  logic [1:0]  req1_op_i = 2'b00;
  logic [31:0] req1_a_i = '0;
  logic [31:0] req1_b_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic        rsp_id_o;
  logic [31:0] rsp_data_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_valid;
  bit          m_id;
  logic [31:0] m_data;
  bit          m_last;
  int          last_g;
  bit          acc0, acc1;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = '0; m_last = 1;
  endtask

  // One clock: check readies mid-cycle, advance the model, check the response after the edge.
  task automatic cycle();
    bit slot;
    int g;
    @(negedge clk_i);
    slot = !m_valid || rsp_ready_i;
    if (req0_valid_i && req1_valid_i) g = m_last ? 0 : 1;
    else if (req0_valid_i)            g = 0;
    else if (req1_valid_i)            g = 1;
    else                              g = -1;
    acc0 = slot && g == 0;
    acc1 = slot && g == 1;
    last_g = (acc0 || acc1) ? g : -1;
    chk("req0_ready", {31'd0, req0_ready_o}, {31'd0, acc0});
    chk("req1_ready", {31'd0, req1_ready_o}, {31'd0, acc1});
    if (acc0) begin
      m_valid = 1; m_id = 0; m_last = 0; m_data = lop(req0_op_i, req0_a_i, req0_b_i);
    end else if (acc1) begin
      m_valid = 1; m_id = 1; m_last = 1; m_data = lop(req1_op_i, req1_a_i, req1_b_i);
    end else if (m_valid && rsp_ready_i) begin
      m_valid = 0;
    end
    @(posedge clk_i);
    #1;
    chk("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, m_valid});
    chk("rsp_id", {31'd0, rsp_id_o}, {31'd0, m_id});
    chk("rsp_data", rsp_data_o, m_data);
  endtask

  initial begin
    logic [31:0] exp_dat [4];
    model_reset();
    exp_dat[0] = 32'h0F0F_0000; exp_dat[1] = 32'h5555_5555;
    exp_dat[2] = 32'h0F0F_0000; exp_dat[3] = 32'h5555_5555;

    // Held in reset with both requesters valid: everything reads 0.
    req0_valid_i = 1; req0_op_i = 2'd0; req0_a_i = 32'hFFFF_0000; req0_b_i = 32'h0F0F_0F0F;
    req1_valid_i = 1; req1_op_i = 2'd2; req1_a_i = 32'hAAAA_AAAA; req1_b_i = 32'hFFFF_FFFF;
    rsp_ready_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset_id", {31'd0, rsp_id_o}, 32'd0);
    chk("reset_data", rsp_data_o, 32'd0);
    chk("reset_ready0", {31'd0, req0_ready_o}, 32'd0);
    chk("reset_ready1", {31'd0, req1_ready_o}, 32'd0);
    rst_ni = 1;

    // Contention: grants 0,1,0,1 starting from the reset value of last_grant.
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("contend_grant", last_g, i % 2);
      chk("contend_data", rsp_data_o, exp_dat[i]);
      chk("contend_id", {31'd0, rsp_id_o}, i % 2);
    end

    // Single OR on requester 0.
    req1_valid_i = 0;
    req0_op_i = 2'd1; req0_a_i = 32'hF0F0_0000; req0_b_i = 32'h0000_0F0F;
    cycle();
    chk("or_grant", last_g, 0);
    chk("or_data", rsp_data_o, 32'hF0F0_0F0F);
    chk("or_id", {31'd0, rsp_id_o}, 32'd0);

    // CSR clear on requester 1.
    req0_valid_i = 0;
    req1_valid_i = 1; req1_op_i = 2'd3; req1_a_i = 32'h0000_1888; req1_b_i = 32'h0000_0008;
    cycle();
    chk("andn_data", rsp_data_o, 32'h0000_1880);
    chk("andn_id", {31'd0, rsp_id_o}, 32'd1);

    // Backpressure for 3 cycles, then drain and accept together.
    req0_valid_i = 1; req0_op_i = 2'd0; req0_a_i = 32'hFFFF_0000; req0_b_i = 32'h0F0F_0F0F;
    rsp_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_grant", last_g, -1);
      chk("bp_data", rsp_data_o, 32'h0000_1880);
      chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
    end
    rsp_ready_i = 1;
    cycle();
    chk("bp_release_grant", last_g, 0);
    chk("bp_release_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("bp_release_data", rsp_data_o, 32'h0F0F_0000);

    // Idle drain keeps the data.
    req0_valid_i = 0; req1_valid_i = 0;
    cycle();
    chk("drain_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("drain_data", rsp_data_o, 32'h0F0F_0000);

    // Mid-cycle reset with a pending response.
    req0_valid_i = 1; req0_op_i = 2'd2; req0_a_i = 32'h1234_5678; req0_b_i = 32'h0F0F_0F0F;
    cycle();
    chk("pre_rst_valid", {31'd0, rsp_valid_o}, 32'd1);
    #2 rst_ni = 0;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("midrst_id", {31'd0, rsp_id_o}, 32'd0);
    chk("midrst_data", rsp_data_o, 32'd0);
    chk("midrst_ready0", {31'd0, req0_ready_o}, 32'd0);
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1;

    // Randomized traffic; requesters hold their request until accepted.
    acc0 = 1; acc1 = 1;
    for (int n = 0; n < 400; n++) begin
      if (!req0_valid_i || acc0) begin
        req0_valid_i = ($urandom_range(0, 9) < 6);
        req0_op_i = 2'($urandom_range(0, 3));
        req0_a_i = $urandom; req0_b_i = $urandom;
      end
      if (!req1_valid_i || acc1) begin
        req1_valid_i = ($urandom_range(0, 9) < 6);
        req1_op_i = 2'($urandom_range(0, 3));
        req1_a_i = $urandom; req1_b_i = $urandom;
      end
      rsp_ready_i = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

- Shares one 32-bit bitwise logic unit (AND / OR / XOR / ANDN) between two requesters.
  - Requester 0: integer ALU issue path.
  - Requester 1: CSR set/clear path (CSRRS = OR, CSRRC = ANDN).
- Round-robin arbitration with valid/ready handshakes on both request ports.
- One registered response slot with its own valid/ready handshake.
- Sits between the decode/issue logic and the bitwise gate datapath. Results return to the writeback mux tagged with the winning requester.

## Interface

- `WIDTH`, 32: operand and result width.
- `clk_i` input 1: the block's single clock; all state updates on the rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req0_valid_i` input 1: requester 0 has an operation pending.
- `req0_ready_o` output 1: requester 0's operation is accepted this cycle.
- `req0_op_i` input 2: operation for requester 0. 00 = AND, 01 = OR, 10 = XOR, 11 = ANDN (a & ~b).
- `req0_a_i`, `req0_b_i` input WIDTH: requester 0 operands.
- `req1_valid_i`, `req1_ready_o`, `req1_op_i`, `req1_a_i`, `req1_b_i`: same as requester 0, for requester 1.
- `rsp_valid_o` output 1: the response register holds a result.
- `rsp_ready_i` input 1: the consumer takes the response this cycle.
- `rsp_id_o` output 1: requester that owns the response (0 or 1).
- `rsp_data_o` output WIDTH: result.

## Operation

- **State**
  - `rsp_valid_o`, `rsp_id_o` and `rsp_data_o` are registers.
  - `last_grant` (1 bit) records the requester most recently accepted.
- **Slot available:** `slot_free = !rsp_valid_o || rsp_ready_i`.
- **Grant** (combinational, at most one per cycle):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant `!last_grant`.
  - Neither valid: no grant.
- **Ready:** `reqN_ready_o = slot_free && grant == N && reqN_valid_i`. The ready of a non-valid requester is always 0.
- **Accept:** a handshake (`reqN_valid_i && reqN_ready_o`) loads the response registers at the next edge:
  - `rsp_valid_o` <= 1
  - `rsp_id_o` <= N
  - `rsp_data_o` <= op(a, b)
  - `last_grant` <= N
- **Drain:** `rsp_valid_o && rsp_ready_i` with no accept in the same cycle clears `rsp_valid_o`. `rsp_data_o` and `rsp_id_o` keep their old values.
- **Simultaneous drain and accept:** the new result replaces the old one, and `rsp_valid_o` stays 1. No bubble.
- **Backpressure:** while `rsp_valid_o && !rsp_ready_i`:
  - both ready outputs are 0;
  - `rsp_*` stays stable;
  - `last_grant` is unchanged.
- **Requester obligation:** once valid is asserted, hold valid, op and operands stable until ready. The block does not buffer unaccepted requests.
- **Op encoding:** all four op encodings are legal. The datapath is purely bitwise, so there is no carry and no width extension; output bit i depends only on input bit i.
- **Fairness:** with both requesters continuously valid and no backpressure, grants alternate 0,1,0,1…
- **Arbitration sees no id:** it does not depend on `rsp_id_o`. A requester may be granted again while its previous result is still being drained, provided `slot_free`.

## Timing

- **Reset values (async assert, `rst_ni` = 0):**
  - `rsp_valid_o` = 0, `rsp_id_o` = 0, `rsp_data_o` = 0.
  - `last_grant` = 1, so requester 0 wins the first contested cycle.
  - Ready outputs are 0 during reset.
- **Reset release:** deassertion is sampled at a rising edge. The first accept is possible in the first cycle after release.
- **Latency:** 1 cycle. A handshake in cycle T gives `rsp_valid_o` = 1 with the result in cycle T+1.
- **Throughput:** 1 operation per cycle while `rsp_ready_i` = 1.
- **Combinational paths:** `reqN_ready_o` depends combinationally on both valid inputs, `last_grant`, `rsp_valid_o` and `rsp_ready_i`. There is no combinational path from operands to any output.
- **Reset mid-operation:** a pending response is discarded (`rsp_valid_o` = 0). Requesters must re-present their operations; no partial state survives.

## Test plan

- **Reset:** assert `rst_ni` = 0 mid-cycle with `rsp_valid_o` = 1 → all outputs 0 immediately, without waiting for a clock edge. After release, `last_grant` = 1 is observable: the first contested grant goes to req0.
- **Single OR:** req0 OR with a = 0xF0F0_0000, b = 0x0000_0F0F, `rsp_ready_i` = 1 → `req0_ready_o` = 1 in cycle T. In T+1: `rsp_valid_o` = 1, `rsp_id_o` = 0, `rsp_data_o` = 0xF0F0_0F0F.
- **Contention:**
  - Both requesters valid for 4 cycles. req0 AND 0xFFFF_0000 & 0x0F0F_0F0F; req1 XOR 0xAAAA_AAAA ^ 0xFFFF_FFFF.
  - Required grants: 0,1,0,1.
  - Required responses: 0x0F0F_0000 (id 0), then 0x5555_5555 (id 1), alternating.
- **CSR clear (ANDN):** req1 op 11 with a = 0x0000_1888, b = 0x0000_0008 → `rsp_data_o` = 0x0000_1880, `rsp_id_o` = 1.
- **Backpressure:**
  - Hold `rsp_ready_i` = 0 for 3 cycles with both requesters valid → both readies 0 and `rsp_*` constant for all 3 cycles.
  - Raise `rsp_ready_i` → the drain and a new accept happen in the same cycle. `rsp_valid_o` stays 1 and the next result appears at the following edge.
- **Idle drain:** a response is pending, no request is valid, and `rsp_ready_i` = 1 → `rsp_valid_o` goes to 0 at the next edge while `rsp_data_o` holds its value.
